// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller.
// Forwarding build option: PIPELINE_HAZARD_FWD_EN (see pipeline_hazard_ctrl).
package pipeline_pkg;

  localparam int RF_IDX_W = 5;

  typedef struct packed {
    logic                valid;
    logic [RF_IDX_W-1:0] rd;
    logic                we;
    logic                is_load;
  } stage_rec_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] S_TYPE = 7'b0100011;
  localparam logic [6:0] B_TYPE = 7'b1100011;
  localparam logic [6:0] U_TYPE = 7'b0110111;
  localparam logic [6:0] J_TYPE = 7'b1101111;
  localparam logic [6:0] LOAD   = 7'b0000011;

  // The youngest producer (EX) takes precedence over the older one (MEM).
  function automatic logic [1:0] fwd_sel_f(input logic match_ex, input logic match_mem);
    if (match_ex)       return FWD_MEM;
    else if (match_mem) return FWD_WB;
    else                return FWD_RF;
  endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares one shadow-pipeline stage record against one decode source register.
module hazard_cmp
  import pipeline_pkg::*;
(
  input  stage_rec_t          stage,
  input  logic [RF_IDX_W-1:0] rs,
  input  logic                rs_used,
  output logic                match
);

  logic unused_load;
  assign unused_load = stage.is_load;

  // x0 is hardwired to zero, so it never creates a dependency.
  assign match = stage.valid & stage.we & rs_used & (rs != '0) & (stage.rd == rs);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// RAW hazard detection, stall/bubble/flush sequencing and forwarding select
// for a 5-stage RV32I pipeline. Forwarding enabled by PIPELINE_HAZARD_FWD_EN.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int REG_W = RF_IDX_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_we,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             bubble,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_rec_t ex_q, mem_q, wb_q;
  stage_rec_t ex_d;
  stage_rec_t stg [3];
  logic [2:0] match_a, match_b;
  logic       stall_raw;
  logic       issue;

  assign stg[0] = ex_q;
  assign stg[1] = mem_q;
  assign stg[2] = wb_q;

  // Index 0 = EX, 1 = MEM, 2 = WB.
  for (genvar s = 0; s < 3; s++) begin : g_cmp
    hazard_cmp u_cmp_a (
      .stage   (stg[s]),
      .rs      (id_rs1),
      .rs_used (id_rs1_used),
      .match   (match_a[s])
    );
    hazard_cmp u_cmp_b (
      .stage   (stg[s]),
      .rs      (id_rs2),
      .rs_used (id_rs2_used),
      .match   (match_b[s])
    );
  end

`ifdef PIPELINE_HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time: its data appears at MEM end.
  assign stall_raw = id_valid & ex_q.is_load & (match_a[0] | match_b[0]);

  logic unused_wb_match;
  assign unused_wb_match = match_a[2] | match_b[2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else if (issue) begin
      fwd_a_sel <= fwd_sel_f(match_a[0], match_a[1]);
      fwd_b_sel <= fwd_sel_f(match_b[0], match_b[1]);
    end else begin
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end
  end
`else
  // The register file is written at the WB edge, so a WB producer still stalls.
  assign stall_raw = id_valid & ((|match_a) | (|match_b));
  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
`endif

  assign issue = id_valid & ~stall_raw & ~ex_branch_taken;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid   = 1'b1;
      ex_d.rd      = id_rd;
      ex_d.we      = id_rd_we;
      ex_d.is_load = id_is_load;
    end
  end

  // A taken branch kills the decode instruction, overriding any pending stall.
  always_comb begin
    stall      = 1'b0;
    bubble     = 1'b0;
    flush_ifid = 1'b0;
    if (rst) begin
      if (ex_branch_taken) begin
        flush_ifid = 1'b1;
        bubble     = 1'b1;
      end else begin
        stall  = stall_raw;
        bubble = stall_raw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage RV32I datapath (IF/ID/EX/MEM/WB) by tracking which register each in-flight instruction will write.
- Detects read-after-write hazards at decode. Drives stall, bubble and IF/ID flush controls to the fetch and decode registers.
- Sits beside the decode stage and consumes decoded fields plus the execute-stage branch resolution.

Parameters:
- REG_W, 5, register index width (32 GPRs)
- CNT_W, 16, width of the stall-cycle performance counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; asserting it clears all state immediately
- id_valid  in  1  decode stage holds a real instruction
- id_rs1  in  REG_W  source register 1 index
- id_rs2  in  REG_W  source register 2 index
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2 (R, S, B types)
- id_rd  in  REG_W  destination index
- id_rd_we  in  1  instruction writes rd (R, I, U, J, load)
- id_is_load  in  1  decode instruction is a load
- ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle
- stall  out  1  hold PC and IF/ID register
- bubble  out  1  inject NOP into ID/EX this cycle
- flush_ifid  out  1  clear IF/ID register (squash the wrong-path fetch)
- fwd_a_sel  out  2  operand-A source for the instruction currently in EX
- fwd_b_sel  out  2  operand-B source for the instruction currently in EX
- stall_cnt  out  CNT_W  saturating count of stall cycles since reset

Behaviour:
- Internal shadow pipeline: three stage records, EX, MEM and WB. Each record holds {valid, rd, we, is_load}.
- The shadow pipeline shifts every cycle: WB<=MEM, MEM<=EX, EX<=issued record or bubble.
- issue = id_valid & ~stall_raw & ~ex_branch_taken. If issue, EX takes the decode fields; otherwise EX takes valid=0.
- A stage "matches" source rsN when all of these hold: stage.valid, stage.we, stage.rd==rsN, rsN!=0, and rsN_used. Register x0 never creates a hazard.
- Without forwarding, stall_raw = id_valid & (any match in EX, MEM or WB). The GPR file is written at the WB clock edge, so a WB match still stalls.
- Branch priority: when ex_branch_taken=1:
  - flush_ifid=1, bubble=1, stall=0.
  - The decode instruction is killed and any pending stall is discarded.
  - The fetch target redirect belongs to the PC logic, not this block.
- Otherwise: stall=stall_raw and bubble=stall_raw. flush_ifid=0.
- Outputs are combinational from stage records and decode inputs. The exceptions are fwd_*_sel (registered, aligned with EX) and stall_cnt (registered).
- stall_cnt increments by 1 each cycle stall=1. It saturates at all-ones and never wraps.
- Reset (rst=0, at any time, including mid-stall): all stage valids=0, fwd_*_sel=2'b00, stall_cnt=0. Consequently stall=0 and bubble=0 while reset is asserted. flush_ifid=0.
- Back-to-back dependent pair without forwarding: exactly 3 stall cycles. Independent instructions: 0 stall cycles.
- The id_rs*/id_rd inputs are ignored while id_valid=0.

Optional Feature:
- Macro: PIPELINE_HAZARD_FWD_EN.
- When defined, forwarding replaces most stalls:
  - stall_raw = id_valid & (match in EX with EX.is_load). This is the load-use case and costs 1 stall cycle.
  - On issue, fwd_*_sel is registered per source:
    - EX match: 2'b01, take the MEM-stage ALU result.
    - Else MEM match: 2'b10, take the WB-stage result or load data.
    - Else: 2'b00, read the register file.
  - The youngest producer wins.
  - After a load-use stall, the load sits in MEM, so the consumer gets 2'b10.
  - On a bubble, fwd_*_sel is registered as 2'b00.
- When undefined: stall uses the EX/MEM/WB rule above, and fwd_*_sel is held at 2'b00.

Decomposition:
- Package pipeline_pkg holds:
  - stage_rec_t struct {valid, rd, we, is_load}
  - constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - opcode constants R_TYPE, I_TYPE, S_TYPE, B_TYPE, U_TYPE, J_TYPE, LOAD, shared with the processor
- One sub-module, hazard_cmp: combinational. Takes one stage_rec_t plus rs, rs_used and returns match. Instantiated 6 times (3 stages x 2 sources).

Test Plan:
- Reset: rst low mid-stall, with EX holding rd=5 and we=1 -> stall, bubble and stall_cnt read 0 immediately. After release, decode of rs1=5 gives no stall.
- No-FWD RAW: "add x5,x1,x2" then "add x6,x5,x3" -> stall=1 for exactly 3 cycles, bubble=1 each cycle, then issue; stall_cnt=3.
- x0 producer: instruction writes rd=0, followed by one reading x0 -> stall never asserts.
- Branch during stall: ex_branch_taken=1 while stall_raw=1 -> flush_ifid=1, bubble=1, stall=0. EX record becomes invalid next cycle.
- FWD (macro defined):
  - back-to-back "add x5" then "sub x7,x5,x5" -> 0 stalls, fwd_a_sel=fwd_b_sel=2'b01 in EX
  - one independent instruction between them -> 2'b10
- FWD load-use: "lw x8" then "add x9,x8,x1" -> 1 stall cycle, then fwd_a_sel=2'b10, fwd_b_sel=2'b00. Also drive stall_cnt to its saturation value and check it holds at all-ones.
